// File: rtl/rv32i_writeback_unit_if.sv
// Write-back bus: ALU/LSU result handshakes, decode issue/query and register-file write port.
// Forwarding signals exist only when WB_BYPASS_EN is defined.
interface rv32i_writeback_unit_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_pending;
    logic        rs2_pending;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        sb_error;
`ifdef WB_BYPASS_EN
    logic        fwd_rs1_hit;
    logic        fwd_rs2_hit;
    logic [31:0] fwd_rs1_data;
    logic [31:0] fwd_rs2_data;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, rs1, rs2,
        output alu_ready, lsu_ready, rs1_pending, rs2_pending,
        output rf_we, rf_rd, rf_data, sb_error
`ifdef WB_BYPASS_EN
        , output fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
`endif
    );

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, rs1, rs2,
        input  alu_ready, lsu_ready, rs1_pending, rs2_pending,
        input  rf_we, rf_rd, rf_data, sb_error
`ifdef WB_BYPASS_EN
        , input fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data
`endif
    );
endinterface

// File: rtl/rv32i_writeback_unit.sv
// RV32I write-back stage: arbitrates ALU/LSU results onto the regfile port and keeps a RAW/WAW scoreboard.
// Optional macro WB_BYPASS_EN adds forwarding of the in-flight regfile write to decode.
module rv32i_writeback_unit #(
    parameter int ARB_MODE = 1,
    parameter int PEND_W   = 2
) (
    input logic                  sys_clk,
    input logic                  sys_reset_n,
    rv32i_writeback_unit_if.slave wb
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic              rr_lsu_q, rr_lsu_d;
    logic              alu_ready_c, lsu_ready_c;
    logic              alu_acc, lsu_acc, any_acc;
    logic [4:0]        acc_rd;
    logic [31:0]       acc_data;
    logic              rf_we_q;
    logic [4:0]        rf_rd_q;
    logic [31:0]       rf_data_q;
    logic [PEND_W-1:0] cnt_q [32];
    logic [PEND_W-1:0] cnt_d [32];
    logic              sb_error_q, sb_error_d;

    // Ready never looks at its own valid, so producers may wait on ready without a comb loop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
        rr_lsu_d    = rr_lsu_q;
        alu_ready_c = 1'b1;
        lsu_ready_c = 1'b1;
        if (ARB_MODE == 0) begin
            alu_ready_c = !wb.lsu_valid;
        end else begin
            alu_ready_c = !wb.lsu_valid || !rr_lsu_q;
            lsu_ready_c = !wb.alu_valid || rr_lsu_q;
            if (wb.alu_valid && wb.lsu_valid) rr_lsu_d = !rr_lsu_q;
        end
    end

    assign alu_acc  = wb.alu_valid && alu_ready_c;
    assign lsu_acc  = wb.lsu_valid && lsu_ready_c;
    assign any_acc  = alu_acc || lsu_acc;
    assign acc_rd   = lsu_acc ? wb.lsu_rd   : wb.alu_rd;
    assign acc_data = lsu_acc ? wb.lsu_data : wb.alu_data;

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            rr_lsu_q  <= 1'b1;
        end else begin
            rf_we_q  <= any_acc && (acc_rd != 5'd0);
            rr_lsu_q <= rr_lsu_d;
            if (any_acc) begin
                rf_rd_q   <= acc_rd;
                rf_data_q <= acc_data;
            end
        end
    end

    // Issue and commit to the same register cancel; saturation/underflow only flag the error.
    always_comb begin
        cnt_d      = cnt_q;
        sb_error_d = sb_error_q;
        cnt_d[0]   = '0;
        for (int i = 1; i < 32; i++) begin
            if ((wb.issue_valid && wb.issue_rd == 5'(i)) && !(rf_we_q && rf_rd_q == 5'(i))) begin
                if (cnt_q[i] == CNT_MAX) sb_error_d = 1'b1;
                else                     cnt_d[i]   = cnt_q[i] + 1'b1;
            end else if (!(wb.issue_valid && wb.issue_rd == 5'(i)) && (rf_we_q && rf_rd_q == 5'(i))) begin
                if (cnt_q[i] == '0) sb_error_d = 1'b1;
                else                cnt_d[i]   = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            // NOTE: unlike a data RAM, every scoreboard entry is reset; decode stalls are derived from it.
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
            sb_error_q <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
            sb_error_q <= sb_error_d;
        end
    end

    assign wb.alu_ready = alu_ready_c;
    assign wb.lsu_ready = lsu_ready_c;
    assign wb.rf_we     = rf_we_q;
    assign wb.rf_rd     = rf_rd_q;
    assign wb.rf_data   = rf_data_q;
    assign wb.sb_error  = sb_error_q;

`ifdef WB_BYPASS_EN
    logic hit1, hit2;
    assign hit1 = rf_we_q && (rf_rd_q == wb.rs1) && (wb.rs1 != 5'd0);
    assign hit2 = rf_we_q && (rf_rd_q == wb.rs2) && (wb.rs2 != 5'd0);
    assign wb.fwd_rs1_hit  = hit1;
    assign wb.fwd_rs2_hit  = hit2;
    assign wb.fwd_rs1_data = rf_data_q;
    assign wb.fwd_rs2_data = rf_data_q;
    // The last outstanding write is being forwarded this cycle, so decode need not stall on it.
    assign wb.rs1_pending = (cnt_q[wb.rs1] != '0) && !(hit1 && cnt_q[wb.rs1] == CNT_ONE);
    assign wb.rs2_pending = (cnt_q[wb.rs2] != '0) && !(hit2 && cnt_q[wb.rs2] == CNT_ONE);
`else
    assign wb.rs1_pending = (cnt_q[wb.rs1] != '0);
    assign wb.rs2_pending = (cnt_q[wb.rs2] != '0);
`endif

endmodule
